// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the MIPS execute stage.
// Optional build macro MDU_EARLY_TERM_EN: multiplies stop once no multiplier bits remain.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_op;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_dvd;
    logic [WIDTH-1:0]     r_dsr;
    logic [WIDTH-1:0]     r_a_raw;
    logic                 r_neg_p;
    logic                 r_neg_a;
    logic                 r_dz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_divzero;

    function automatic logic [WIDTH-1:0] f_cneg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_cneg2(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? -v : v;
    endfunction

    logic                 w_sgn;
    logic                 w_is_div_start;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_is_div;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_prod_s;
    logic [2*WIDTH-1:0]   w_hilo;
    logic                 w_last;

    assign w_sgn          = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
    assign w_is_div_start = (Op == OP_DIV) || (Op == OP_DIVU);
    assign w_a_mag        = f_cneg(w_sgn && A[WIDTH-1], A);
    assign w_b_mag        = f_cneg(w_sgn && B[WIDTH-1], B);
    assign w_is_div       = (r_op == OP_DIV) || (r_op == OP_DIVU);

    // Restoring step: the shifted partial remainder is one bit wider than the divisor.
    assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge     = w_shift >= {1'b0, r_dsr};
    assign w_diff   = w_shift[WIDTH-1:0] - r_dsr;
    assign w_prod_s = f_cneg2(r_neg_p, r_prod);
    assign w_hilo   = {r_hi, r_lo};

`ifdef MDU_EARLY_TERM_EN
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (!w_is_div && (r_mplier[WIDTH-1:1] == '0));
`else
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_a_raw   <= '0;
            r_neg_p   <= 1'b0;
            r_neg_a   <= 1'b0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start && !Flush) begin
                        r_divzero <= 1'b0;
                        if (Op == OP_MTHI) begin
                            r_hi <= A;
                        end else if (Op == OP_MTLO) begin
                            r_lo <= A;
                        end else begin
                            r_op     <= Op;
                            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                            r_mplier <= w_b_mag;
                            r_prod   <= '0;
                            r_rem    <= '0;
                            r_dvd    <= w_a_mag;
                            r_dsr    <= w_b_mag;
                            r_a_raw  <= A;
                            r_neg_p  <= w_sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                            r_neg_a  <= w_sgn && A[WIDTH-1];
                            r_dz     <= w_is_div_start && (B == '0);
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_RUN;
                        end
                    end
                end
                // RUN: one multiplier bit or one quotient bit per edge
                S_RUN: begin
                    if (Flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (w_is_div) begin
                            r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                            r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                        end else begin
                            if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                            r_mcand  <= r_mcand << 1;
                            r_mplier <= r_mplier >> 1;
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) r_state <= S_FIX;
                    end
                end
                // FIX: sign correction and architectural write-back
                S_FIX: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (!Flush) begin
                        r_done <= 1'b1;
                        if (w_is_div) begin
                            r_divzero <= r_dz;
                            if (r_dz) begin
                                r_hi <= r_a_raw;
                                r_lo <= '1;
                            end else begin
                                r_hi <= f_cneg(r_neg_a, r_rem);
                                r_lo <= f_cneg(r_neg_p, r_dvd);
                            end
                        end else if (r_op == OP_MADD) begin
                            {r_hi, r_lo} <= w_hilo + w_prod_s;
                        end else if (r_op == OP_MSUB) begin
                            {r_hi, r_lo} <= w_hilo - w_prod_s;
                        end else begin
                            {r_hi, r_lo} <= w_prod_s;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Hi      = r_hi;
    assign Lo      = r_lo;
    assign Busy    = r_busy;
    assign Done    = r_done;
    assign DivZero = r_divzero;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a WIDTH=32 instance plus a WIDTH=8 instance.
module tb_mult_div_unit;
    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
    localparam logic [2:0] MADD = 3'b100, MSUB = 3'b101, MTHI = 3'b110, MTLO = 3'b111;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset;
    logic        s32, f32, busy32, done32, dz32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        s8, f8, busy8, done8, dz8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int total = 0;
    int bad   = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) u32 (
        .Clk(Clk), .Reset(Reset), .Start(s32), .Op(op32), .A(a32), .B(b32), .Flush(f32),
        .Hi(hi32), .Lo(lo32), .Busy(busy32), .Done(done32), .DivZero(dz32));

    mult_div_unit #(.WIDTH(8), .CNT_W(4)) u8 (
        .Clk(Clk), .Reset(Reset), .Start(s8), .Op(op8), .A(a8), .B(b8), .Flush(f8),
        .Hi(hi8), .Lo(lo8), .Busy(busy8), .Done(done8), .DivZero(dz8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Edges from the accepting edge to Done for a multiply with multiplier magnitude bmag.
    function automatic int mul_lat(input int w, input logic [63:0] bmag);
`ifdef MDU_EARLY_TERM_EN
        int k;
        k = 1;
        for (int i = 0; i < w; i++) if (bmag[i]) k = i + 1;
        return k + 1;
`else
        if (bmag == 64'd0) return w + 1;
        return w + 1;
`endif
    endfunction

    task automatic start32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        op32 = op; a32 = a; b32 = b; s32 = 1'b1;
        @(posedge Clk);
        #1 s32 = 1'b0;
    endtask

    task automatic start8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge Clk);
        op8 = op; a8 = a; b8 = b; s8 = 1'b1;
        @(posedge Clk);
        #1 s8 = 1'b0;
    endtask

    task automatic wait_done(input bit w8, input string tag, input int exp_lat);
        int  n;
        bit  got;
        n = 0;
        got = 1'b0;
        for (int i = 1; i <= 200 && !got; i++) begin
            @(posedge Clk);
            #1;
            n = i;
            if ((w8 ? done8 : done32) === 1'b1) got = 1'b1;
        end
        if (!got) n = -1;
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        @(posedge Clk);
        #1;
        chk({tag, "_done_width"}, 64'(w8 ? done8 : done32), 64'd0);
    endtask

    initial begin
        int ndone;
        Reset = 1'b0;
        s32 = 0; f32 = 0; op32 = '0; a32 = '0; b32 = '0;
        s8 = 0; f8 = 0; op8 = '0; a8 = '0; b8 = '0;
        #2 Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_hi", 64'(hi32), 64'd0);
        chk("rst_lo", 64'(lo32), 64'd0);
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_done", 64'(done32), 64'd0);
        chk("rst_dz", 64'(dz32), 64'd0);
        @(negedge Clk) Reset = 1'b0;

        // Reset in the middle of a MULT
        start32(MTHI, 32'h0000_AAAA, 32'd0);
        chk("mthi_pre", 64'(hi32), 64'h0000_AAAA);
        start32(MULT, 32'd123, 32'd456);
        repeat (4) @(posedge Clk);
        @(negedge Clk) Reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy32), 64'd0);
        chk("midrst_hilo", {hi32, lo32}, 64'd0);
        @(negedge Clk) Reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            if (done32) ndone++;
        end
        chk("midrst_nodone", 64'(ndone), 64'd0);

        start32(MULTU, 32'd3, 32'd5);
        chk("multu_busy", 64'(busy32), 64'd1);
        wait_done(1'b0, "multu", mul_lat(32, 64'd5));
        chk("multu_hilo", {hi32, lo32}, 64'd15);

        start32(MULT, 32'hFFFF_FFF9, 32'd6);
        wait_done(1'b0, "mult_neg", mul_lat(32, 64'd6));
        chk("mult_neg_hilo", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFD6);

        start32(DIV, 32'hFFFF_FFEF, 32'd5);
        wait_done(1'b0, "div_neg", 33);
        chk("div_neg_hilo", {hi32, lo32}, 64'hFFFF_FFFE_FFFF_FFFD);
        chk("div_neg_dz", 64'(dz32), 64'd0);

        start32(DIVU, 32'd17, 32'd0);
        wait_done(1'b0, "divu_z", 33);
        chk("divu_z_hilo", {hi32, lo32}, 64'h0000_0011_FFFF_FFFF);
        chk("divu_z_dz", 64'(dz32), 64'd1);

        start32(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b0, "div_min", 33);
        chk("div_min_hilo", {hi32, lo32}, 64'h0000_0000_8000_0000);

        // Direct writes followed by accumulate
        start32(MTHI, 32'h1, 32'd0);
        chk("mthi_busy", 64'(busy32), 64'd0);
        chk("mthi_dz_clr", 64'(dz32), 64'd0);
        start32(MTLO, 32'h2, 32'd0);
        chk("mtlo_hilo", {hi32, lo32}, 64'h0000_0001_0000_0002);
        start32(MADD, 32'h0001_0000, 32'h0001_0000);
        wait_done(1'b0, "madd", mul_lat(32, 64'h1_0000));
        chk("madd_hilo", {hi32, lo32}, 64'h0000_0002_0000_0002);
        start32(MSUB, 32'h0001_0000, 32'h0001_0000);
        wait_done(1'b0, "msub", mul_lat(32, 64'h1_0000));
        chk("msub_hilo", {hi32, lo32}, 64'h0000_0001_0000_0002);

        // Flush in RUN, with an ignored MTHI while busy
        start32(MULTU, 32'd9, 32'hFFFF_FFFF);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        op32 = MTHI; a32 = 32'h0000_DEAD; s32 = 1'b1;
        @(posedge Clk);
        #1 s32 = 1'b0;
        chk("busy_ign_busy", 64'(busy32), 64'd1);
        chk("busy_ign_hi", 64'(hi32), 64'd1);
        repeat (6) @(posedge Clk);
        @(negedge Clk) f32 = 1'b1;
        @(posedge Clk);
        #1 f32 = 1'b0;
        chk("flush_busy", 64'(busy32), 64'd0);
        chk("flush_done", 64'(done32), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            if (done32) ndone++;
        end
        chk("flush_nodone", 64'(ndone), 64'd0);
        chk("flush_hilo", {hi32, lo32}, 64'h0000_0001_0000_0002);

        // Flush and Start together in IDLE: Flush wins
        @(negedge Clk);
        op32 = MULT; a32 = 32'd2; b32 = 32'd2; s32 = 1'b1; f32 = 1'b1;
        @(posedge Clk);
        #1 s32 = 1'b0; f32 = 1'b0;
        chk("flush_start_busy", 64'(busy32), 64'd0);
        @(negedge Clk);
        op32 = MTHI; a32 = 32'h77; s32 = 1'b1; f32 = 1'b1;
        @(posedge Clk);
        #1 s32 = 1'b0; f32 = 1'b0;
        chk("flush_mthi_hi", 64'(hi32), 64'd1);

        // Narrow instance
        start8(DIV, 8'h80, 8'hFF);
        wait_done(1'b1, "div8_min", 9);
        chk("div8_min_hilo", 64'({hi8, lo8}), 64'h0080);
        start8(MULTU, 8'h25, 8'h01);
        wait_done(1'b1, "mul8_b1", mul_lat(8, 64'd1));
        chk("mul8_b1_hilo", 64'({hi8, lo8}), 64'h0025);
        start8(MULT, 8'hFD, 8'h7F);
        wait_done(1'b1, "mul8_neg", mul_lat(8, 64'h7F));
        chk("mul8_neg_hilo", 64'({hi8, lo8}), 64'hFE83);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
